// File: rtl/processing_top.sv
// Red-object detection stage. It pops RGB444 pixels from the upstream async FIFO and classifies
// each one as red or not through a fixed-latency pipeline. Results land in a 32-entry FWFT buffer.
// Credits (buffered + in-flight) gate the pops, so the buffer can never overflow.
module processing_top #(
  parameter int unsigned PROCESSING_LATENCY = 12,
  parameter logic [3:0]  RED_MIN            = 4'd8,
  parameter logic [3:0]  GB_MAX             = 4'd4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_flush,
  input  logic [11:0] i_data,
  input  logic        i_almostempty,
  output logic        o_rd_async_fifo,
  input  logic        i_obuf_rd,
  output logic [11:0] o_obuf_data,
  output logic [5:0]  o_obuf_fill,
  output logic        o_obuf_full,
  output logic        o_obuf_almostfull,
  output logic        o_obuf_empty,
  output logic        o_obuf_almostempty
);

  localparam int Lat = int'(PROCESSING_LATENCY);

  logic [Lat-1:0] valid_q;
  logic [11:0]    pix_q [Lat];
  logic [5:0]     inflight_q;
  logic [5:0]     fill_q;
  logic [4:0]     wr_ptr_q;
  logic [4:0]     rd_ptr_q;
  logic [11:0]    mem [32];

  logic        pop;
  logic        wr_en;
  logic        rd_en;
  logic        is_red;
  logic [11:0] class_pix;
  logic [6:0]  credits_used;

  assign is_red = (i_data[11:8] >= RED_MIN) && (i_data[7:4] <= GB_MAX) &&
                  (i_data[3:0] <= GB_MAX);
  assign class_pix = is_red ? 12'hF00 : 12'h000;

  // A credit is held by every buffered word and every pixel still in the pipeline.
  assign credits_used = {1'b0, fill_q} + {1'b0, inflight_q};
  assign pop   = !i_rstn && !i_flush && !i_almostempty && (credits_used < 7'd32);
  // Full-buffer guard is defensive only; credits make it unreachable.
  assign wr_en = valid_q[Lat-1] && (fill_q != 6'd32);
  assign rd_en = i_obuf_rd && (fill_q != 6'd0);

  assign o_rd_async_fifo = pop;

  // Pipeline valid bits: stage 0 takes the pop strobe, bubbles shift through as zeros.
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      valid_q <= '0;
    end else if (i_flush) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= pop;
      for (int i = 1; i < Lat; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Pipeline data: classification result registered in stage 0, then a plain shift.
  always_ff @(posedge i_clk) begin
    pix_q[0] <= class_pix;
    for (int i = 1; i < Lat; i++) begin
      pix_q[i] <= pix_q[i-1];
    end
  end

  // In-flight credit count: +1 on pop, -1 when the last stage retires into the buffer.
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      inflight_q <= '0;
    end else if (i_flush) begin
      inflight_q <= '0;
    end else begin
      case ({pop, valid_q[Lat-1]})
        2'b10:   inflight_q <= inflight_q + 6'd1;
        2'b01:   inflight_q <= inflight_q - 6'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Output buffer pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 5'd1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 5'd1;
      case ({wr_en, rd_en})
        2'b10:   fill_q <= fill_q + 6'd1;
        2'b01:   fill_q <= fill_q - 6'd1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Buffer storage; no reset needed since the pointers define what is live.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= pix_q[Lat-1];
    end
  end

  // FWFT head and flags, all derived from registered state.
  always_comb begin
    o_obuf_data        = (fill_q == 6'd0) ? 12'h000 : mem[rd_ptr_q];
    o_obuf_fill        = fill_q;
    o_obuf_full        = (fill_q == 6'd32);
    o_obuf_almostfull  = (fill_q >= 6'd30);
    o_obuf_empty       = (fill_q == 6'd0);
    o_obuf_almostempty = (fill_q <= 6'd2);
  end

endmodule

// File: tb/tb_processing_top.sv
// Self-checking bench for processing_top: a transaction-level model (queues of in-flight
// pixels with due times plus a buffer queue) predicts pops, head data, fill and flags each cycle.
module tb_processing_top;

  localparam int LAT = 12;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [11:0] din;
  logic        almostempty;
  logic        rd_fifo;
  logic        obuf_rd;
  logic [11:0] obuf_data;
  logic [5:0]  fill;
  logic        full;
  logic        almostfull;
  logic        empty;
  logic        almost_empty;

  processing_top #(
    .PROCESSING_LATENCY(LAT),
    .RED_MIN(4'd8),
    .GB_MAX(4'd4)
  ) dut (
    .i_clk(clk),
    .i_rstn(rst),
    .i_flush(flush),
    .i_data(din),
    .i_almostempty(almostempty),
    .o_rd_async_fifo(rd_fifo),
    .i_obuf_rd(obuf_rd),
    .o_obuf_data(obuf_data),
    .o_obuf_fill(fill),
    .o_obuf_full(full),
    .o_obuf_almostfull(almostfull),
    .o_obuf_empty(empty),
    .o_obuf_almostempty(almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int model_pops = 0;
  int dut_pops = 0;
  int dut_outs = 0;

  logic [11:0] obq[$];
  logic [11:0] pend_d[$];
  int          pend_due[$];

  function automatic logic [11:0] classify(input logic [11:0] p);
    return ((p[11:8] >= 4'd8) && (p[7:4] <= 4'd4) && (p[3:0] <= 4'd4)) ? 12'hF00 : 12'h000;
  endfunction

  // One clock: drive at negedge, compare DUT against the model, then advance the model.
  task automatic step(input logic r, input logic fl, input logic ae, input logic [11:0] d,
                      input logic rd);
    int          n;
    logic        exp_pop;
    logic [11:0] exp_data;
    logic [3:0]  exp_flags;
    logic [3:0]  got_flags;
    @(negedge clk);
    rst = r; flush = fl; almostempty = ae; din = d; obuf_rd = rd;
    #1;
    n         = obq.size();
    exp_pop   = !r && !fl && !ae && ((n + pend_d.size()) < 32);
    exp_data  = (n > 0) ? obq[0] : 12'h000;
    exp_flags = {n == 32, n >= 30, n == 0, n <= 2};
    got_flags = {full, almostfull, empty, almost_empty};
    checks++;
    assert (rd_fifo === exp_pop) else begin
      errors++;
      $error("FAIL pop t=%0t got=%b exp=%b", $time, rd_fifo, exp_pop);
    end
    checks++;
    assert (fill === 6'(n)) else begin
      errors++;
      $error("FAIL fill t=%0t got=%0d exp=%0d", $time, fill, n);
    end
    checks++;
    assert (obuf_data === exp_data) else begin
      errors++;
      $error("FAIL data t=%0t got=%h exp=%h", $time, obuf_data, exp_data);
    end
    checks++;
    assert (got_flags === exp_flags) else begin
      errors++;
      $error("FAIL flags{full,af,empty,ae} t=%0t got=%b exp=%b", $time, got_flags, exp_flags);
    end
    if (rd_fifo === 1'b1) dut_pops++;
    if (rd && (empty === 1'b0)) dut_outs++;
    edge_n++;
    if (r || fl) begin
      obq.delete();
      pend_d.delete();
      pend_due.delete();
    end else begin
      if (rd && n > 0) void'(obq.pop_front());
      while (pend_due.size() > 0 && pend_due[0] == edge_n) begin
        obq.push_back(pend_d.pop_front());
        void'(pend_due.pop_front());
      end
      if (exp_pop) begin
        pend_d.push_back(classify(d));
        pend_due.push_back(edge_n + LAT);
        model_pops++;
      end
    end
  endtask

  task automatic check_count(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int p0, o0, cyc, x, y;
    logic [11:0] pix;
    logic [11:0] bvals [6];
    rst = 1'b1; flush = 1'b0; almostempty = 1'b1; din = '0; obuf_rd = 1'b0;

    // Reset held 10 cycles, then idle with an empty upstream.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 12'h800, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 12'h800, 1'b0);
    check_count("pops_after_reset", dut_pops, 0);

    // Classification boundaries.
    bvals[0] = 12'h800; bvals[1] = 12'h700; bvals[2] = 12'h844;
    bvals[3] = 12'h850; bvals[4] = 12'h805; bvals[5] = 12'hF44;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, bvals[i], 1'b0);
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 12'h000, 1'b1);

    // Continuous frame 64x48 with a red box; consumer always reading.
    step(1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
    p0 = dut_pops; o0 = dut_outs; cyc = 0;
    while ((model_pops - model_pops) == 0 && (dut_pops - p0) < 3072 && cyc < 6000) begin
      x = (dut_pops - p0) % 64;
      y = (dut_pops - p0) / 64;
      pix = (x >= 16 && x < 48 && y >= 12 && y < 36) ? 12'hF00 : 12'h000;
      step(1'b0, 1'b0, 1'b0, pix, 1'b1);
      cyc++;
    end
    for (int i = 0; i < LAT + 4; i++) step(1'b0, 1'b0, 1'b1, 12'h000, 1'b1);
    check_count("frame_pops", dut_pops - p0, 3072);
    check_count("frame_cycles", cyc, 3072);
    check_count("frame_outs", dut_outs - o0, 3072);

    // Backpressure: downstream stalled, upstream always ready.
    step(1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
    p0 = dut_pops;
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b0, 12'($urandom), 1'b0);
    check_count("bp_pops", dut_pops - p0, 32);
    check_count("bp_fill", int'(fill), 32);
    step(1'b0, 1'b0, 1'b1, 12'h000, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 12'($urandom), 1'b0);
    check_count("bp_one_more", dut_pops - p0, 33);

    // Flush with 5 buffered and 10 in flight, all red; later traffic is non-red.
    step(1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 12'hF00, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 12'hF00, 1'b0);
    check_count("pre_flush_fill", int'(fill), 5);
    step(1'b0, 1'b1, 1'b0, 12'hF00, 1'b0);
    p0 = dut_pops; o0 = dut_outs;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 12'h123, 1'b1);
    for (int i = 0; i < LAT + 4; i++) step(1'b0, 1'b0, 1'b1, 12'h000, 1'b1);
    check_count("post_flush_outs", dut_outs - o0, dut_pops - p0);
    check_count("post_flush_pops", dut_pops - p0, 40);

    // Upstream starvation, almostempty toggling every 3 cycles, random reads.
    step(1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
    p0 = dut_pops; o0 = dut_outs;
    for (int i = 0; i < 120; i++)
      step(1'b0, 1'b0, 1'(((i / 3) % 2)), 12'($urandom), 1'($urandom_range(3) != 0));
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1, 12'h000, 1'b1);
    check_count("starve_pops", dut_pops - p0, 60);
    check_count("starve_outs", dut_outs - o0, dut_pops - p0);

    // Random mix of traffic, stalls and occasional flush.
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom_range(63) == 0), 1'($urandom_range(3) == 0), 12'($urandom),
           1'($urandom_range(1)));
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1, 12'h000, 1'b1);
    check_count("drained_fill", int'(fill), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
